// File: rtl/led_counter_pkg.sv
// ---------------------------------------------------------------------------
// led_counter_pkg
// Shared types for the LED counter bank: configuration command encoding,
// configuration handshake states, and a helper that sizes select fields so
// that single-entry configurations still get a one-bit port.
// ---------------------------------------------------------------------------
package led_counter_pkg;

    typedef enum logic [1:0] {
        CMD_UP    = 2'b00,
        CMD_DOWN  = 2'b01,
        CMD_LOAD  = 2'b10,
        CMD_CLEAR = 2'b11
    } cfg_cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_e;

    // Width of a field that selects one of n items; never narrower than 1.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_counter_channel.sv
// ---------------------------------------------------------------------------
// led_counter_channel
// One WIDTH-bit wrapping counter with its own up/down mode.
//   clk1, rstn : clock, asynchronous active-low reset
//   tick       : shared prescaled step strobe
//   apply      : configuration command targets this channel this cycle
//   cmd, data  : captured configuration command and load value
//   cnt        : current count
//   tc         : one-cycle terminal-count pulse, coincident with the
//                wrapped count value
// ---------------------------------------------------------------------------
module led_counter_channel
    import led_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk1,
    input  logic             rstn,
    input  logic             tick,
    input  logic             apply,
    input  cfg_cmd_e         cmd,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic mode_down;
    logic down_eff;
    logic wrap;

    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] value,
                                                    input logic             down);
        return down ? (value - 1'b1) : (value + 1'b1);
    endfunction

    // A mode command arriving together with a tick already steers that
    // tick, so the direction used this cycle is the post-command one.
    always_comb begin
        down_eff = mode_down;
        if (apply && (cmd == CMD_UP)) begin
            down_eff = 1'b0;
        end else if (apply && (cmd == CMD_DOWN)) begin
            down_eff = 1'b1;
        end
    end

    assign wrap = down_eff ? (cnt == '0) : (cnt == '1);

    // Load/clear override the tick step and never raise tc.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            mode_down <= 1'b0;
            tc        <= 1'b0;
        end else begin
            mode_down <= down_eff;
            tc        <= 1'b0;
            if (apply && (cmd == CMD_LOAD)) begin
                cnt <= data;
            end else if (apply && (cmd == CMD_CLEAR)) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= step_count(cnt, down_eff);
                tc  <= wrap;
            end
        end
    end

endmodule

// File: rtl/led_counter_bank.sv
// ---------------------------------------------------------------------------
// led_counter_bank
// CHANNELS independent wrapping counters advanced by a shared prescaled tick,
// reconfigured through a two-state valid/ready handshake, with a registered
// LED view of the top bits of one selected channel.
//   clk1, rstn         : clock, asynchronous active-low reset
//   en                 : global count enable (gates the prescaler)
//   cfg_valid/ready    : configuration handshake (ready from state only)
//   cfg_ch/cmd/data    : target channel, command, load value
//   cnt_flat           : all counters, channel i at [i*WIDTH +: WIDTH]
//   tc                 : per-channel terminal-count pulses
//   led_sel            : LED source channel (out of range shows 0)
//   led                : registered top LED_BITS of the selected counter
// ---------------------------------------------------------------------------
module led_counter_bank
    import led_counter_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int PRESCALE = 1,
    parameter  int LED_BITS = 4,
    localparam int CH_W     = sel_w(CHANNELS)
) (
    input  logic                       clk1,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CH_W-1:0]            cfg_ch,
    input  logic [1:0]                 cfg_cmd,
    input  logic [WIDTH-1:0]           cfg_data,
    output logic [CHANNELS*WIDTH-1:0]  cnt_flat,
    output logic [CHANNELS-1:0]        tc,
    input  logic [CH_W-1:0]            led_sel,
    output logic [LED_BITS-1:0]        led
);

    localparam int             PW         = sel_w(PRESCALE);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       presc;
    logic                tick;

    cfg_state_e          state;
    cfg_state_e          state_next;
    logic                accept;
    logic                apply;

    logic [CH_W-1:0]     cap_ch;
    cfg_cmd_e            cap_cmd;
    logic [WIDTH-1:0]    cap_data;

    logic [WIDTH-1:0]    cnt_arr [CHANNELS];
    logic [LED_BITS-1:0] led_next;

    // Prescaler: holds while en is low; with PRESCALE=1 it stays at 0 and
    // tick simply follows en.
    assign tick = en && (presc == PRESC_LAST);

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : (presc + 1'b1);
        end
    end

    // Configuration handshake: one accepted command per two cycles.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    accept     = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign apply = (state == APPLY);

    // Captured command payload; only meaningful while in APPLY, so it needs
    // no reset (a reset returns the FSM to IDLE and the payload is ignored).
    always_ff @(posedge clk1) begin
        if (accept) begin
            cap_ch   <= cfg_ch;
            cap_cmd  <= cfg_cmd_e'(cfg_cmd);
            cap_data <= cfg_data;
        end
    end

    // A captured channel number with no matching instance simply hits
    // nothing, which is how out-of-range targets are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_counter_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk1  (clk1),
            .rstn  (rstn),
            .tick  (tick),
            .apply (apply && (cap_ch == CH_W'(i))),
            .cmd   (cap_cmd),
            .data  (cap_data),
            .cnt   (cnt_arr[i]),
            .tc    (tc[i])
        );
        assign cnt_flat[i*WIDTH +: WIDTH] = cnt_arr[i];
    end

    // LED mux by comparison rather than direct indexing so that select
    // values beyond the last channel fall through to 0.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (led_sel == CH_W'(i)) begin
                led_next = cnt_arr[i][WIDTH-1 -: LED_BITS];
            end
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_led_counter_bank
// Directed and randomized stimulus for led_counter_bank. The main instance
// (WIDTH=8, CHANNELS=4, PRESCALE=1) is compared every cycle against a
// behavioural model; a second instance (WIDTH=8, CHANNELS=3, PRESCALE=4)
// covers the prescaler, out-of-range channel commands and LED select.
// ---------------------------------------------------------------------------
module tb_led_counter_bank;

    logic        clk1 = 1'b0;
    logic        rstn;

    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_cmd;
    logic [7:0]  cfg_data;
    logic [31:0] cnt_flat;
    logic [3:0]  tc;
    logic [1:0]  led_sel;
    logic [3:0]  led;

    logic        en4;
    logic        cfg_valid4;
    logic        cfg_ready4;
    logic [1:0]  cfg_ch4;
    logic [1:0]  cfg_cmd4;
    logic [7:0]  cfg_data4;
    logic [23:0] cnt_flat4;
    logic [2:0]  tc4;
    logic [1:0]  led_sel4;
    logic [3:0]  led4;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the main instance.
    int       m_cnt [4];
    bit       m_down[4];
    bit [3:0] m_tc;
    bit [3:0] m_led;
    bit       m_pend;
    int       m_pch;
    int       m_pcmd;
    int       m_pdata;

    led_counter_bank #(
        .WIDTH(8), .CHANNELS(4), .PRESCALE(1), .LED_BITS(4)
    ) u_dut (
        .clk1(clk1), .rstn(rstn), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_cmd(cfg_cmd), .cfg_data(cfg_data),
        .cnt_flat(cnt_flat), .tc(tc), .led_sel(led_sel), .led(led)
    );

    led_counter_bank #(
        .WIDTH(8), .CHANNELS(3), .PRESCALE(4), .LED_BITS(4)
    ) u_dut4 (
        .clk1(clk1), .rstn(rstn), .en(en4),
        .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4),
        .cfg_ch(cfg_ch4), .cfg_cmd(cfg_cmd4), .cfg_data(cfg_data4),
        .cnt_flat(cnt_flat4), .tc(tc4), .led_sel(led_sel4), .led(led4)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("comparison %s differs", tag);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c]  = 0;
            m_down[c] = 1'b0;
        end
        m_tc   = '0;
        m_led  = '0;
        m_pend = 1'b0;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_flat;
        exp_flat = '0;
        for (int c = 0; c < 4; c++) begin
            exp_flat = exp_flat | (32'(m_cnt[c] & 255) << (8 * c));
        end
        check("cnt_flat", cnt_flat, exp_flat);
        check("tc", 32'(tc), 32'(m_tc));
        check("led", 32'(led), 32'(m_led));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    // Advance one clk1 cycle: predict from the current inputs, clock, compare.
    task automatic step();
        int       ncnt[4];
        bit [3:0] ntc;
        bit [3:0] nled;
        bit       hit;
        bit       tick;
        tick = en;
        ntc  = '0;
        nled = 4'((m_cnt[led_sel] >> 4) & 15);
        for (int c = 0; c < 4; c++) begin
            hit     = m_pend && (m_pch == c);
            ncnt[c] = m_cnt[c];
            if (hit && m_pcmd == 0) m_down[c] = 1'b0;
            if (hit && m_pcmd == 1) m_down[c] = 1'b1;
            if (hit && m_pcmd == 2) begin
                ncnt[c] = m_pdata;
            end else if (hit && m_pcmd == 3) begin
                ncnt[c] = 0;
            end else if (tick) begin
                if (m_down[c]) begin
                    ntc[c]  = (m_cnt[c] == 0);
                    ncnt[c] = (m_cnt[c] + 255) % 256;
                end else begin
                    ntc[c]  = (m_cnt[c] == 255);
                    ncnt[c] = (m_cnt[c] + 1) % 256;
                end
            end
        end
        if (m_pend) begin
            m_pend = 1'b0;
        end else if (cfg_valid) begin
            m_pend  = 1'b1;
            m_pch   = int'(cfg_ch);
            m_pcmd  = int'(cfg_cmd);
            m_pdata = int'(cfg_data);
        end
        @(posedge clk1);
        #1;
        for (int c = 0; c < 4; c++) m_cnt[c] = ncnt[c];
        m_tc  = ntc;
        m_led = nled;
        check_outputs();
    endtask

    initial begin
        int exp3;

        rstn = 1'b0;
        en = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_cmd = '0; cfg_data = '0; led_sel = '0;
        en4 = 1'b0; cfg_valid4 = 1'b0; cfg_ch4 = '0; cfg_cmd4 = '0; cfg_data4 = '0; led_sel4 = '0;
        model_reset();
        repeat (3) @(posedge clk1);
        #1;
        check_outputs();
        check("dut4_reset_cnt", 32'(cnt_flat4), 32'h0);
        check("dut4_reset_ready", 32'(cfg_ready4), 32'h1);
        rstn = 1'b1;

        // Prescaler on the PRESCALE=4 instance: 12 enabled cycles, 5 held.
        en4 = 1'b1;
        repeat (12) step();
        check("p4_after_12", 32'(cnt_flat4), 32'h030303);
        en4 = 1'b0;
        repeat (5) step();
        check("p4_hold", 32'(cnt_flat4), 32'h030303);

        // Load ch1 of the small instance and view it on the LEDs.
        cfg_valid4 = 1'b1; cfg_ch4 = 2'd1; cfg_cmd4 = 2'b10; cfg_data4 = 8'hA7; led_sel4 = 2'd1;
        step();
        check("p4_ready_apply", 32'(cfg_ready4), 32'h0);
        cfg_valid4 = 1'b0;
        step();
        step();
        check("p4_led_ch1", 32'(led4), 32'hA);
        check("p4_load_ch1", 32'(cnt_flat4), 32'h03A703);
        // Out-of-range channel: accepted, changes nothing.
        cfg_valid4 = 1'b1; cfg_ch4 = 2'd3; cfg_data4 = 8'h55;
        step();
        cfg_valid4 = 1'b0;
        step();
        check("p4_ch_oob", 32'(cnt_flat4), 32'h03A703);
        check("p4_tc_none", 32'(tc4), 32'h0);
        led_sel4 = 2'd3;
        step();
        check("p4_led_oob", 32'(led4), 32'h0);

        // Full wrap at PRESCALE=1: 256 ticks bring every counter back to 0.
        en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            led_sel = 2'($urandom_range(0, 3));
            step();
        end
        check("wrap_cnt", cnt_flat, 32'h0);
        check("wrap_tc", 32'(tc), 32'hF);
        step();
        check("wrap_tc_pulse", 32'(tc), 32'h0);

        // Load ch2 = 0xFE, count up through the wrap.
        en = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_cmd = 2'b10; cfg_data = 8'hFE;
        step();
        cfg_valid = 1'b0;
        step();
        check("load_ch2", 32'(cnt_flat[23:16]), 32'hFE);
        en = 1'b1;
        step();
        check("ch2_ff", 32'(cnt_flat[23:16]), 32'hFF);
        step();
        check("ch2_wrap", 32'(cnt_flat[23:16]), 32'h00);
        check("ch2_tc_only", 32'(tc), 32'h4);

        // Clear then mode-down ch1 with cfg_valid held back-to-back.
        en = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_cmd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) cfg_cmd = 2'b01;
            check("b2b_ready", 32'(cfg_ready), 32'((k % 2) == 0));
            step();
        end
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        check("ch1_down_wrap", 32'(cnt_flat[15:8]), 32'hFF);
        check("ch1_tc", 32'(tc), 32'h2);

        // Load ch0 = 0x10 in the same cycle as a tick.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_cmd = 2'b10; cfg_data = 8'h10;
        step();
        cfg_valid = 1'b0;
        exp3 = (m_cnt[3] + 1) % 256;
        step();
        check("load_vs_tick", 32'(cnt_flat[7:0]), 32'h10);
        check("ch3_steps", 32'(cnt_flat[31:24]), 32'(exp3));

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_cmd   = 2'($urandom_range(0, 3));
            cfg_data  = 8'($urandom);
            led_sel   = 2'($urandom_range(0, 3));
            step();
        end

        // Reset asserted while a load is in APPLY.
        en = 1'b0; cfg_valid = 1'b0;
        step();
        step();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_cmd = 2'b10; cfg_data = 8'hAA;
        step();
        cfg_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("rst_cnt", cnt_flat, 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        model_reset();
        @(posedge clk1);
        #1;
        rstn = 1'b1;
        step();
        step();
        check("rst_load_lost", cnt_flat, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_counter_bank.md
# led_counter_bank

Parametrised multi-channel successor to the single free-running LED counter. It holds CHANNELS independent WIDTH-bit counters, advanced by a shared prescaled tick, each with a run-time direction. A two-state configuration handshake loads, clears or re-moves any channel, and a registered LED port shows the top bits of a selected channel. It sits between the on-chip oscillator domain (clk1) and the board LED pins.

## Interface
- WIDTH, 32, counter width per channel (≥ LED_BITS)
- CHANNELS, 4, number of counters (≥1)
- PRESCALE, 1, clk1 cycles per count tick (≥1)
- LED_BITS, 4, LED output width
- clk1  in  1  counter clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  global count enable; gates the prescaler
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel
- cfg_cmd  in  2  00 mode up, 01 mode down, 10 load cfg_data, 11 clear to 0
- cfg_data  in  WIDTH  load value
- cnt_flat  out  CHANNELS*WIDTH  all counters, channel i at [i*WIDTH +: WIDTH]
- tc  out  CHANNELS  per-channel terminal-count pulse
- led_sel  in  max(1,$clog2(CHANNELS))  LED source channel
- led  out  LED_BITS  LED drive

## Operation
- Reset: all counters 0, all modes up, prescaler 0, tc 0, led 0, FSM IDLE (cfg_ready 1).
- Prescaler: increments while en; tick = en && presc == PRESCALE-1, then presc returns to 0. en low holds presc. PRESCALE=1 ⇒ tick every cycle en is high.
- On tick each channel steps: up: cnt+1; down: cnt-1.
- Wrap: up at 2^WIDTH-1 → 0; down at 0 → 2^WIDTH-1; tc[i] high for exactly one cycle with the wrapped value. No tc on load/clear.
- Config FSM: IDLE — cfg_ready=1; cfg_valid&&cfg_ready captures ch/cmd/data, → APPLY. APPLY — cfg_ready=0; command applied at end of cycle, → IDLE. Max one accepted command per two cycles.
- Collision: APPLY on channel i overrides that channel's tick step in the same cycle (load/clear wins; mode change applies and the tick step uses the new mode). Other channels step normally.
- cfg_ch ≥ CHANNELS: accepted, no effect.
- led = registered cnt[led_sel][WIDTH-1 -: LED_BITS]; led_sel ≥ CHANNELS → 0.
- rstn asserted mid-APPLY: command discarded, everything to reset values immediately.

## Timing
- Tick to counter update: counter changes on the clk1 edge at which tick is high.
- tc: registered, asserted the cycle after the wrapping edge, concurrent with the wrapped counter value.
- Config: accept edge N; new value/mode visible after edge N+1; cfg_ready high again after edge N+1.
- led: one cycle behind cnt_flat and led_sel.
- No combinational input-to-output paths except cfg_ready (from FSM state only).

## Structure
- Package led_counter_pkg: cfg_cmd_e (CMD_UP, CMD_DOWN, CMD_LOAD, CMD_CLEAR), cfg_state_e (IDLE, APPLY).
- Sub-module led_counter_channel: one counter with mode register, step, wrap, tc, load/clear override; instantiated CHANNELS times by generate.
- Top holds prescaler, config FSM, capture registers, LED mux.

## Test plan
- Reset then en=1, PRESCALE=1, WIDTH=8: after 256 cycles every counter returns to 0x00, tc all-ones for one cycle.
- PRESCALE=4, en=1 for 12 cycles then 0 for 5: counters = 3, unchanged during en=0.
- Load ch2 with 0xFE, mode up: counter reaches 0xFF, then 0x00 with tc[2] pulse; other tc bits stay 0.
- Mode down on ch1 from 0: next tick gives 0xFF with tc[1]; back-to-back cfg_valid shows cfg_ready low every second cycle.
- Load ch0 = 0x10 in the same cycle as a tick: ch0 = 0x10 (not 0x11); ch3 steps normally.
- rstn pulsed during APPLY: load lost, all outputs at reset values, led=0, cfg_ready=1.
